// File: rtl/counter_cmd_ctrl_pkg.sv
// Shared opcodes, FSM encodings and frame types for the counter command controller.
package counter_cmd_ctrl_pkg;

  localparam int unsigned CMD_DATA_W = 8;
  localparam int unsigned OP_W       = 2;

  localparam logic [OP_W-1:0] OP_LOAD = 2'b00;
  localparam logic [OP_W-1:0] OP_RUN  = 2'b01;
  localparam logic [OP_W-1:0] OP_STOP = 2'b10;
  localparam logic [OP_W-1:0] OP_OE   = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;

endpackage

// File: rtl/counter_cmd_ctrl_if.sv
// Serial command input and counter-control output bundle.
interface counter_cmd_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic              cs_n;
  logic              bit_vld;
  logic              ser_in;
  logic              ctr_load;
  logic [DATA_W-1:0] ctr_data;
  logic              ctr_en;
  logic              ctr_oe;
  logic              running;
  logic              busy;
  logic              frame_err;

  modport master (
    output cs_n, bit_vld, ser_in,
    input  ctr_load, ctr_data, ctr_en, ctr_oe, running, busy, frame_err
  );

  modport slave (
    input  cs_n, bit_vld, ser_in,
    output ctr_load, ctr_data, ctr_en, ctr_oe, running, busy, frame_err
  );
endinterface

// File: rtl/counter_cmd_ctrl_tick_gen.sv
// Programmable prescaler: one registered tick every div+1 cycles while active.
module counter_cmd_ctrl_tick_gen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             active
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;

  // start wins over stop; a restart suppresses any tick due in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      cnt    <= '0;
      tick   <= 1'b0;
      active <= 1'b0;
    end else if (start) begin
      div_q  <= div;
      cnt    <= '0;
      tick   <= 1'b0;
      active <= 1'b1;
    end else if (stop) begin
      cnt    <= '0;
      tick   <= 1'b0;
      active <= 1'b0;
    end else if (active) begin
      if (cnt == div_q) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + DIV_W'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/counter_cmd_ctrl.sv
// Serial command front end for the programmable counter: frame capture, decode,
// output registers and prescaled count enable.
module counter_cmd_ctrl
  import counter_cmd_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = CMD_DATA_W
) (
  input logic               clk,
  input logic               rst_n,
  counter_cmd_ctrl_if.slave bus
);

  localparam int unsigned FRAME_W = DATA_W + OP_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  logic [1:0]         state, state_nxt;
  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   bit_cnt;

  logic               shift_c;
  logic               clear_c;
  logic               exec_ok_c;
  logic               exec_bad_c;
  logic               start_c;
  logic               stop_c;
  logic [OP_W-1:0]    op_c;
  logic [DATA_W-1:0]  payload_c;

  assign op_c      = shreg[FRAME_W-1 -: OP_W];
  assign payload_c = shreg[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-cycle control strobes; a frame is judged on the cs_n rise
  always_comb begin
    state_nxt  = state;
    shift_c    = 1'b0;
    clear_c    = 1'b0;
    exec_ok_c  = 1'b0;
    exec_bad_c = 1'b0;
    start_c    = 1'b0;
    stop_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!bus.cs_n) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bus.cs_n) begin
          state_nxt  = ST_EXEC;
          exec_ok_c  = (bit_cnt == CNT_FULL);
          exec_bad_c = (bit_cnt != CNT_FULL);
        end else begin
          shift_c = bus.bit_vld;
        end
      end
      ST_EXEC: begin
        state_nxt = ST_IDLE;
        clear_c   = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
        clear_c   = 1'b1;
      end
    endcase
    start_c = exec_ok_c && (op_c == OP_RUN);
    stop_c  = exec_ok_c && (op_c == OP_STOP);
  end

  // Frame capture; the count saturates so over-length frames stay detectable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clear_c) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift_c) begin
      shreg <= {shreg[FRAME_W-2:0], bus.ser_in};
      if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ctr_load  <= 1'b0;
      bus.ctr_data  <= '0;
      bus.ctr_oe    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.ctr_load  <= 1'b0;
      bus.frame_err <= exec_bad_c;
      bus.busy      <= (state_nxt == ST_SHIFT);
      if (exec_ok_c) begin
        case (op_c)
          OP_LOAD: begin
            bus.ctr_data <= payload_c;
            bus.ctr_load <= 1'b1;
          end
          OP_OE:   bus.ctr_oe <= payload_c[0];
          default: ;
        endcase
      end
    end
  end

  counter_cmd_ctrl_tick_gen #(
    .DIV_W (DATA_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_c),
    .stop   (stop_c),
    .div    (payload_c),
    .tick   (bus.ctr_en),
    .active (bus.running)
  );

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Directed bench for counter_cmd_ctrl: framed commands with hand-computed responses.
module tb_counter_cmd_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  counter_cmd_ctrl_if #(.DATA_W(8)) bus ();

  counter_cmd_ctrl #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the cycle right after the cs_n rise is sampled
  task automatic send_frame(input logic [15:0] val, input int n);
    bus.cs_n = 1'b0;
    step();
    step();
    for (int i = n - 1; i >= 0; i--) begin
      bus.bit_vld = 1'b1;
      bus.ser_in  = val[i];
      step();
    end
    bus.bit_vld = 1'b0;
    bus.ser_in  = 1'b0;
    bus.cs_n    = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cs_n = 1'b1; bus.bit_vld = 1'b0; bus.ser_in = 1'b0;
    step(); step();
    total++; if (bus.ctr_load !== 1'b0) begin bad++; $display("FAIL rst_load: got %b want 0", bus.ctr_load); end
    total++; if (bus.ctr_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", bus.ctr_data); end
    total++; if (bus.ctr_en !== 1'b0) begin bad++; $display("FAIL rst_en: got %b want 0", bus.ctr_en); end
    total++; if (bus.ctr_oe !== 1'b0) begin bad++; $display("FAIL rst_oe: got %b want 0", bus.ctr_oe); end
    total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL rst_running: got %b want 0", bus.running); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", bus.frame_err); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load();
    send_frame(16'h005A, 10);
    total++; if (bus.ctr_load !== 1'b1) begin bad++; $display("FAIL load_pulse: got %b want 1", bus.ctr_load); end
    total++; if (bus.ctr_data !== 8'h5A) begin bad++; $display("FAIL load_data: got %h want 5a", bus.ctr_data); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL load_err: got %b want 0", bus.frame_err); end
    step();
    total++; if (bus.ctr_load !== 1'b0) begin bad++; $display("FAIL load_width: got %b want 0", bus.ctr_load); end
    total++; if (bus.ctr_data !== 8'h5A) begin bad++; $display("FAIL load_hold: got %h want 5a", bus.ctr_data); end
  endtask

  task automatic test_run_stop();
    logic exp;
    send_frame(16'h0103, 10);
    total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL run_running: got %b want 1", bus.running); end
    for (int k = 1; k <= 13; k++) begin
      exp = (k >= 5) && (((k - 5) % 4) == 0);
      total++; if (bus.ctr_en !== exp) begin bad++; $display("FAIL run_div3_tick k=%0d: got %b want %b", k, bus.ctr_en, exp); end
      step();
    end
    send_frame(16'h02A5, 10);
    total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL stop_running: got %b want 0", bus.running); end
    for (int k = 1; k <= 8; k++) begin
      total++; if (bus.ctr_en !== 1'b0) begin bad++; $display("FAIL stop_tick k=%0d: got %b want 0", k, bus.ctr_en); end
      step();
    end
  endtask

  task automatic test_div0_oe();
    send_frame(16'h0100, 10);
    total++; if (bus.ctr_en !== 1'b0) begin bad++; $display("FAIL div0_first: got %b want 0", bus.ctr_en); end
    step();
    for (int k = 2; k <= 6; k++) begin
      total++; if (bus.ctr_en !== 1'b1) begin bad++; $display("FAIL div0_tick k=%0d: got %b want 1", k, bus.ctr_en); end
      step();
    end
    send_frame(16'h0301, 10);
    total++; if (bus.ctr_oe !== 1'b1) begin bad++; $display("FAIL oe_on: got %b want 1", bus.ctr_oe); end
    total++; if (bus.ctr_en !== 1'b1) begin bad++; $display("FAIL div0_during_oe: got %b want 1", bus.ctr_en); end
    send_frame(16'h0300, 10);
    total++; if (bus.ctr_oe !== 1'b0) begin bad++; $display("FAIL oe_off: got %b want 0", bus.ctr_oe); end
    send_frame(16'h0200, 10);
    total++; if (bus.ctr_en !== 1'b0) begin bad++; $display("FAIL div0_stop: got %b want 0", bus.ctr_en); end
  endtask

  task automatic test_len_err();
    send_frame(16'h00A5, 10);
    send_frame(16'h0301, 10);
    send_frame(16'h0102, 10);
    // 9-bit, 11-bit and empty frames
    for (int t = 0; t < 3; t++) begin
      int n;
      n = (t == 0) ? 9 : (t == 1) ? 11 : 0;
      bus.cs_n = 1'b0;
      step(); step();
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL err_busy n=%0d: got %b want 1", n, bus.busy); end
      for (int i = 0; i < n; i++) begin
        bus.bit_vld = 1'b1; bus.ser_in = 1'b0;
        step();
      end
      bus.bit_vld = 1'b0; bus.cs_n = 1'b1;
      step();
      total++; if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL err_pulse n=%0d: got %b want 1", n, bus.frame_err); end
      total++; if (bus.ctr_load !== 1'b0) begin bad++; $display("FAIL err_load n=%0d: got %b want 0", n, bus.ctr_load); end
      total++; if (bus.ctr_data !== 8'hA5) begin bad++; $display("FAIL err_data n=%0d: got %h want a5", n, bus.ctr_data); end
      total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL err_running n=%0d: got %b want 1", n, bus.running); end
      total++; if (bus.ctr_oe !== 1'b1) begin bad++; $display("FAIL err_oe n=%0d: got %b want 1", n, bus.ctr_oe); end
      step();
      total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL err_width n=%0d: got %b want 0", n, bus.frame_err); end
    end
    send_frame(16'h0200, 10);
  endtask

  task automatic test_reset_mid();
    send_frame(16'h0301, 10);
    bus.cs_n = 1'b0;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      bus.bit_vld = 1'b1; bus.ser_in = 1'b1;
      step();
    end
    rst_n = 1'b0;
    bus.cs_n = 1'b1; bus.bit_vld = 1'b0; bus.ser_in = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    total++; if (bus.ctr_oe !== 1'b0) begin bad++; $display("FAIL midrst_oe: got %b want 0", bus.ctr_oe); end
    step();
    rst_n = 1'b1;
    step();
    send_frame(16'h00FF, 10);
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL midrst_err: got %b want 0", bus.frame_err); end
    total++; if (bus.ctr_load !== 1'b1) begin bad++; $display("FAIL midrst_load: got %b want 1", bus.ctr_load); end
    total++; if (bus.ctr_data !== 8'hFF) begin bad++; $display("FAIL midrst_data: got %h want ff", bus.ctr_data); end
  endtask

  task automatic test_load_during_run();
    int  t0;
    int  d;
    logic exp;
    send_frame(16'h0101, 10);
    t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      d = cyc - t0;
      exp = (d >= 2) && ((d % 2) == 0);
      total++; if (bus.ctr_en !== exp) begin bad++; $display("FAIL ldrun_pre d=%0d: got %b want %b", d, bus.ctr_en, exp); end
      step();
    end
    send_frame(16'h0010, 10);
    total++; if (bus.ctr_load !== 1'b1) begin bad++; $display("FAIL ldrun_load: got %b want 1", bus.ctr_load); end
    total++; if (bus.ctr_data !== 8'h10) begin bad++; $display("FAIL ldrun_data: got %h want 10", bus.ctr_data); end
    for (int k = 0; k < 5; k++) begin
      d = cyc - t0;
      exp = (d >= 2) && ((d % 2) == 0);
      total++; if (bus.ctr_en !== exp) begin bad++; $display("FAIL ldrun_cadence d=%0d: got %b want %b", d, bus.ctr_en, exp); end
      step();
    end
    send_frame(16'h0200, 10);
  endtask

  task automatic test_back_to_back();
    bus.cs_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.bit_vld = 1'b1; bus.ser_in = 1'b1;
      step();
    end
    bus.bit_vld = 1'b0; bus.ser_in = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_vld_busy: got %b want 0", bus.busy); end
    send_frame(16'h0033, 10);
    total++; if (bus.ctr_data !== 8'h33) begin bad++; $display("FAIL b2b_first: got %h want 33", bus.ctr_data); end
    send_frame(16'h00CC, 10);
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL b2b_err: got %b want 0", bus.frame_err); end
    total++; if (bus.ctr_load !== 1'b1) begin bad++; $display("FAIL b2b_load: got %b want 1", bus.ctr_load); end
    total++; if (bus.ctr_data !== 8'hCC) begin bad++; $display("FAIL b2b_second: got %h want cc", bus.ctr_data); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_run_stop();
    test_div0_oe();
    test_len_err();
    test_reset_mid();
    test_load_during_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
